ssd_scan_driver: RTL and testbench
==================================

// Module: ssd_scan_driver
// PURPOSE
//  Display end of the 20-bit ssd code bus driven by the lock ASM: 4 digits x 5-bit codes.
//  Decodes each code to seven-segment and time-multiplexes one shared seg bus over 4 anodes.
//  Blinks selected digits at a slow rate and latches the code word once per frame (tear-free).
//  Sits between the ASM outputs and the board's common-anode 4-digit display pins.
// PARAMETERS
//  SCAN_DIV    50000     clk cycles per digit slot (>= GUARD+2)
//  GUARD       16        leading cycles of each slot with all anodes off (anti-ghosting, < SCAN_DIV)
//  BLINK_HALF  25000000  clk cycles per blink half-period (1 Hz at 50 MHz)
// PORTS
//  clk         in   1   system clock, all logic on rising edge
//  rst         in   1   asynchronous, active-low reset
//  ssd_in      in   20  code word {d0,d1,d2,d3}, d0=[19:15] is leftmost digit
//  blink_mask  in   4   per-digit blink enable, bit3=d0 ... bit0=d3
//  an          out  4   anode selects, active-low, an[3]=d0 ... an[0]=d3
//  seg         out  7   segments {g,f,e,d,c,b,a}, active-low
//  frame_sync  out  1   1-cycle pulse when a new frame is latched
// BEHAVIOUR
//  Reset (rst=0, async): an=4'b1111, seg=7'b1111111, frame_sync=0, blink_phase=0,
//   shadow code = 4 x 5'h10 (blank), shadow mask=0, digit=3, scan_cnt=SCAN_DIV-1.
//  Scan: scan_cnt counts 0..SCAN_DIV-1 and wraps; on wrap, digit advances 0->1->2->3->0.
//   Because of the reset values, the first edge after rst release wraps into digit 0.
//  Frame latch: on every wrap of digit 3->0, shadow<=ssd_in, shadow_mask<=blink_mask and
//   frame_sync pulses 1 in that cycle. Changes on ssd_in/blink_mask between latches are ignored.
//  Outputs are registered: an/seg in cycle N+1 are a function of digit/scan_cnt/shadow/phase in cycle N.
//   If scan_cnt < GUARD: an=1111 and seg=1111111.
//   Otherwise: exactly one anode low (the current digit); seg=decode(shadow code of that digit).
//   If blink_phase=1 and shadow_mask bit of that digit=1: seg=1111111 (anode still driven).
//  Blink: free-running counter 0..BLINK_HALF-1; blink_phase toggles on wrap; phase 0 = visible.
//   The blink counter is independent of the scan counter; a phase change takes effect mid-slot.
//  Code map, seg={g..a} active-low:
//   00..0F hex 0-F: 0=1000000 1=1111001 2=0100100 3=0110000 4=0011001 5=0010010 6=0000010
//    7=1111000 8=0000000 9=0010000 A=0001000 b=0000011 C=1000110 d=0100001 E=0000110 F=0001110
//   10 blank=1111111   11 '-' (tire)=0111111   12 'L'=1000111   13 'P'=0001100
//   14 'n'=0101011    15 'r'=0101111   16 'U'=1000001   17 'o'=0100011   18..1F blank
//  A reset asserted mid-frame blanks the outputs immediately (async). After release,
//   scanning restarts at digit 0 with a fresh latch. No state survives across reset.
// TESTING (bench params SCAN_DIV=8, GUARD=2, BLINK_HALF=64)
//  1 rst=0 any inputs -> an=1111, seg=1111111, frame_sync=0, all held while rst=0.
//  2 release rst, ssd_in={0C,12,05,0D}, mask=0 -> frame_sync at 1st edge; then per slot 2 cycles
//    an=1111, 6 cycles an=0111 seg=1000110 / 1011 1000111 / 1101 0010010 / 1110 0100001.
//  3 change ssd_in to {11,11,11,11} mid-frame -> current frame unchanged; after next frame_sync
//    all digits show 0111111.
//  4 mask=4'b1000 -> d0 seg=1111111 for 64 cycles, then visible for 64; d1-d3 never blank.
//  5 sweep codes 00..1F on d3 -> seg matches the table; 18..1F give 1111111.
//  6 assert rst during slot of d2 -> outputs blank in same cycle; after release, d0 first, frame_sync=1.

Source files
------------

// File: rtl/ssd_scan_driver.sv
// Four-digit common-anode seven-segment scan driver.
// Latches a 4 x 5-bit code word once per frame, decodes each code to
// segments, multiplexes a single seg bus over four anodes with a short
// blank guard at the start of every slot, and blinks masked digits.
module ssd_scan_driver #(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned GUARD      = 16,
    parameter int unsigned BLINK_HALF = 25000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] ssd_in,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_sync
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned BLINK_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;

    localparam logic [SCAN_W-1:0]  SCAN_LAST  = SCAN_W'(SCAN_DIV - 1);
    localparam logic [SCAN_W-1:0]  GUARD_END  = SCAN_W'(GUARD);
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_HALF - 1);

    typedef enum logic [1:0] {
        DIG0 = 2'd0,
        DIG1 = 2'd1,
        DIG2 = 2'd2,
        DIG3 = 2'd3
    } digit_t;

    digit_t             digit;
    logic [SCAN_W-1:0]  scan_cnt;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_phase;
    logic [19:0]        shadow;
    logic [3:0]         shadow_mask;

    logic [4:0]         cur_code;
    logic               cur_blink;
    logic [3:0]         cur_an;

    // Code to active-low {g,f,e,d,c,b,a}; unused codes are blank.
    function automatic logic [6:0] decode(input logic [4:0] code);
        logic [6:0] s;
        case (code)
            5'h00: s = 7'b1000000;
            5'h01: s = 7'b1111001;
            5'h02: s = 7'b0100100;
            5'h03: s = 7'b0110000;
            5'h04: s = 7'b0011001;
            5'h05: s = 7'b0010010;
            5'h06: s = 7'b0000010;
            5'h07: s = 7'b1111000;
            5'h08: s = 7'b0000000;
            5'h09: s = 7'b0010000;
            5'h0A: s = 7'b0001000;
            5'h0B: s = 7'b0000011;
            5'h0C: s = 7'b1000110;
            5'h0D: s = 7'b0100001;
            5'h0E: s = 7'b0000110;
            5'h0F: s = 7'b0001110;
            5'h11: s = 7'b0111111;
            5'h12: s = 7'b1000111;
            5'h13: s = 7'b0001100;
            5'h14: s = 7'b0101011;
            5'h15: s = 7'b0101111;
            5'h16: s = 7'b1000001;
            5'h17: s = 7'b0100011;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Select the latched code, blink enable and anode pattern of the current digit.
    always_comb begin
        cur_code  = 5'h10;
        cur_blink = 1'b0;
        cur_an    = 4'b1111;
        unique case (digit)
            DIG0: begin cur_code = shadow[19:15]; cur_blink = shadow_mask[3]; cur_an = 4'b0111; end
            DIG1: begin cur_code = shadow[14:10]; cur_blink = shadow_mask[2]; cur_an = 4'b1011; end
            DIG2: begin cur_code = shadow[9:5];   cur_blink = shadow_mask[1]; cur_an = 4'b1101; end
            DIG3: begin cur_code = shadow[4:0];   cur_blink = shadow_mask[0]; cur_an = 4'b1110; end
        endcase
    end

    // Slot counter, digit sequencing, once-per-frame latch and registered display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt    <= SCAN_LAST;
            digit       <= DIG3;
            shadow      <= {4{5'h10}};
            shadow_mask <= '0;
            frame_sync  <= 1'b0;
            an          <= '1;
            seg         <= '1;
        end else begin
            frame_sync <= 1'b0;
            if (scan_cnt == SCAN_LAST) begin
                scan_cnt <= '0;
                case (digit)
                    DIG0: digit <= DIG1;
                    DIG1: digit <= DIG2;
                    DIG2: digit <= DIG3;
                    DIG3: begin
                        digit       <= DIG0;
                        shadow      <= ssd_in;
                        shadow_mask <= blink_mask;
                        frame_sync  <= 1'b1;
                    end
                endcase
            end else begin
                scan_cnt <= scan_cnt + SCAN_W'(1);
            end

            if (scan_cnt < GUARD_END) begin
                an  <= '1;
                seg <= '1;
            end else begin
                an  <= cur_an;
                seg <= (blink_phase && cur_blink) ? 7'b1111111 : decode(cur_code);
            end
        end
    end

    // Free-running blink half-period counter; phase 0 shows masked digits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
        end else begin
            blink_cnt <= blink_cnt + BLINK_W'(1);
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Scoreboard bench for ssd_scan_driver: the driver computes the expected
// outputs from an edge count since reset release and pushes them into a
// queue; the monitor pops and compares on each falling edge.
module tb_ssd_scan_driver;

    localparam int unsigned S = 8;
    localparam int unsigned G = 2;
    localparam int unsigned B = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [19:0] ssd_in = '0;
    logic [3:0]  blink_mask = '0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_sync;

    ssd_scan_driver #(.SCAN_DIV(S), .GUARD(G), .BLINK_HALF(B)) dut (
        .clk        (clk),
        .rst        (rst),
        .ssd_in     (ssd_in),
        .blink_mask (blink_mask),
        .an         (an),
        .seg        (seg),
        .frame_sync (frame_sync)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       fs;
    } exp_t;

    exp_t        sb_q[$];
    int unsigned checks = 0;
    int unsigned passes = 0;

    logic [6:0] seg_tab [0:31] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110,
        7'b1111111, 7'b0111111, 7'b1000111, 7'b0001100,
        7'b0101011, 7'b0101111, 7'b1000001, 7'b0100011,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111,
        7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111
    };

    // Model state: edges since reset release and the latched frame.
    int unsigned t = 0;
    logic [19:0] m_shadow = {4{5'h10}};
    logic [3:0]  m_mask = '0;

    function automatic int unsigned scan_of(int unsigned u);
        return (u + S - 1) % S;
    endfunction

    function automatic int unsigned dig_of(int unsigned u);
        return ((u + 4*S - 1) / S) % 4;
    endfunction

    // Display seen one cycle after a state with u edges since release.
    function automatic exp_t model_out(int unsigned u, logic [19:0] sh, logic [3:0] mk);
        exp_t        e;
        int unsigned dg;
        logic [4:0]  code;
        dg    = dig_of(u);
        e.fs  = 1'b0;
        e.an  = 4'b1111;
        e.seg = 7'b1111111;
        if (scan_of(u) >= G) begin
            e.an[3-dg] = 1'b0;
            code = 5'(sh >> (5*(3-dg)));
            if (((u / B) % 2 == 1) && mk[3-dg])
                e.seg = 7'b1111111;
            else
                e.seg = seg_tab[code];
        end
        return e;
    endfunction

    task automatic step(input bit assert_rst);
        exp_t e;
        @(posedge clk);
        #1;
        if (assert_rst) begin
            rst = 1'b0;
            #1;
        end
        if (!rst) begin
            t        = 0;
            m_shadow = {4{5'h10}};
            m_mask   = '0;
            e.an     = 4'b1111;
            e.seg    = 7'b1111111;
            e.fs     = 1'b0;
        end else begin
            t = t + 1;
            e = model_out(t - 1, m_shadow, m_mask);
            if ((t - 1) % (4*S) == 0) begin
                m_shadow = ssd_in;
                m_mask   = blink_mask;
                e.fs     = 1'b1;
            end
        end
        sb_q.push_back(e);
    endtask

    // Monitor: compare every output against the oldest expected entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                checks++;
                if (an === e.an) passes++;
                else $display("FAIL an @%0t: got %b exp %b", $time, an, e.an);
                checks++;
                if (seg === e.seg) passes++;
                else $display("FAIL seg @%0t: got %b exp %b", $time, seg, e.seg);
                checks++;
                if (frame_sync === e.fs) passes++;
                else $display("FAIL frame_sync @%0t: got %b exp %b", $time, frame_sync, e.fs);
            end
        end
    end

    initial begin
        int unsigned guard;
        #2 rst = 1'b0;

        // Held in reset while inputs wander.
        for (int i = 0; i < 4; i++) begin
            step(1'b0);
            ssd_in     = 20'($urandom);
            blink_mask = 4'($urandom);
        end

        // Fixed word, then a mid-frame change that must wait for the next latch.
        ssd_in     = {5'h0C, 5'h12, 5'h05, 5'h0D};
        blink_mask = 4'b0000;
        rst        = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b0);
        ssd_in = {4{5'h11}};
        for (int i = 0; i < 3*4*S; i++) step(1'b0);

        // Blink on d0 across several half-periods.
        ssd_in     = {5'h01, 5'h02, 5'h03, 5'h04};
        blink_mask = 4'b1000;
        for (int i = 0; i < 3*B + 4*S; i++) step(1'b0);

        // Sweep every code on d3.
        blink_mask = 4'b0000;
        for (int c = 0; c < 32; c++) begin
            ssd_in = {5'h10, 5'h10, 5'h10, 5'(c)};
            for (int i = 0; i < 4*S; i++) step(1'b0);
        end

        // Random words and masks changing at arbitrary points.
        for (int i = 0; i < 600; i++) begin
            step(1'b0);
            if ($urandom_range(7) == 0) begin
                ssd_in     = 20'($urandom);
                blink_mask = 4'($urandom);
            end
        end

        // Reset while d2 is lit, then restart.
        guard = 0;
        while (!(dig_of(t) == 2 && scan_of(t) == G + 2) && guard < 64) begin
            step(1'b0);
            guard++;
        end
        checks++;
        if (guard < 64) passes++;
        else $display("FAIL reach_d2: got timeout exp digit 2 within 64 cycles");
        step(1'b1);
        step(1'b0);
        step(1'b0);
        ssd_in     = {5'h13, 5'h14, 5'h15, 5'h16};
        blink_mask = 4'b0101;
        rst        = 1'b1;
        for (int i = 0; i < 2*4*S; i++) step(1'b0);

        @(negedge clk);
        #1;
        checks++;
        if (sb_q.size() == 0) passes++;
        else $display("FAIL drain: got %0d pending exp 0", sb_q.size());

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
